window_select_ctrl: RTL and testbench

//   Per-scanline window sequencer for the priority evaluation stage. On each line

---
 rtl/window_select_ctrl.sv | 172 +++++++++++++++++
 tb/tb_window_select_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_select_ctrl.sv
// rtl/window_select_ctrl.sv - per-scanline window sequencer: latches window config on line start,
// then streams one window select and layer mask per pixel under a valid/ready handshake.
module window_select_ctrl #(
  parameter int SCREEN_W = 240,
  parameter int XW       = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          line_start,
  input  logic [XW-1:0] vcount,
  input  logic [2:0]    win_en,
  input  logic [15:0]   win0h,
  input  logic [15:0]   win1h,
  input  logic [15:0]   win0v,
  input  logic [15:0]   win1v,
  input  logic [13:0]   winin,
  input  logic [13:0]   winout,
  input  logic          obj_valid,
  input  logic          obj_win,
  output logic          obj_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] pix_x,
  output logic [1:0]    win_sel,
  output logic [5:0]    win_mask,
  output logic          busy,
  output logic          line_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XW-1:0] X_MAX  = XW'(SCREEN_W);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);

  localparam logic [1:0] SEL_WIN0 = 2'd0;
  localparam logic [1:0] SEL_WIN1 = 2'd1;
  localparam logic [1:0] SEL_OBJ  = 2'd2;
  localparam logic [1:0] SEL_OUT  = 2'd3;

  state_t        state_q, state_nxt;
  logic [XW-1:0] x_q;
  logic [2:0]    en_q;
  logic [15:0]   h0_q, h1_q;
  logic          v0_q, v1_q;
  logic [5:0]    mask_w0_q, mask_w1_q, mask_obj_q, mask_out_q;
  // Horizontal+vertical+enable hit for the pixel currently presented in x_q.
  logic          hit0_q, hit1_q;

  logic          run;
  logic          handshake;
  logic          last_px;
  logic [XW-1:0] x_next;
  logic          v0_new, v1_new;

  wire unused_fields = &{1'b0, winin[7:6], winout[7:6]};

  function automatic logic in_range(input logic [XW-1:0] c,
                                    input logic [XW-1:0] e1,
                                    input logic [XW-1:0] e2);
    if (e1 < e2)
      return (c >= e1) && (c < e2);
    else if (e1 > e2)
      return (c >= e1) || (c < e2);
    else
      return 1'b0;
  endfunction

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] e);
    return (e > X_MAX) ? X_MAX : e;
  endfunction

  function automatic logic hit_h(input logic [XW-1:0] c, input logic [15:0] h);
    return in_range(c, clamp_x(h[15:8]), clamp_x(h[7:0]));
  endfunction

  assign run       = (state_q == S_RUN);
  assign handshake = out_valid & out_ready;
  assign last_px   = (x_q == X_LAST);
  assign x_next    = x_q + XW'(1);
  assign v0_new    = in_range(vcount, win0v[15:8], win0v[7:0]);
  assign v1_new    = in_range(vcount, win1v[15:8], win1v[7:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      S_IDLE: if (line_start) state_nxt = S_RUN;
      S_RUN: begin
        if (line_start)
          state_nxt = S_RUN;
        else if (handshake && last_px)
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = line_start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config is only sampled on line_start, so register writes mid-line are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q        <= '0;
      en_q       <= '0;
      h0_q       <= '0;
      h1_q       <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      mask_w0_q  <= '0;
      mask_w1_q  <= '0;
      mask_obj_q <= '0;
      mask_out_q <= '0;
      hit0_q     <= 1'b0;
      hit1_q     <= 1'b0;
    end else if (line_start) begin
      x_q        <= '0;
      en_q       <= win_en;
      h0_q       <= win0h;
      h1_q       <= win1h;
      v0_q       <= v0_new;
      v1_q       <= v1_new;
      mask_w0_q  <= winin[5:0];
      mask_w1_q  <= winin[13:8];
      mask_obj_q <= winout[13:8];
      mask_out_q <= winout[5:0];
      hit0_q     <= win_en[0] & v0_new & hit_h('0, win0h);
      hit1_q     <= win_en[1] & v1_new & hit_h('0, win1h);
    end else if (run && handshake) begin
      x_q        <= last_px ? '0 : x_next;
      hit0_q     <= en_q[0] & v0_q & hit_h(x_next, h0_q);
      hit1_q     <= en_q[1] & v1_q & hit_h(x_next, h1_q);
    end
  end

  always_comb begin
    out_valid = run & (obj_valid | ~en_q[2]);
    obj_ready = out_valid & out_ready;
    busy      = run;
    line_done = (state_q == S_DONE);
    pix_x     = x_q;
    win_sel   = 2'd0;
    win_mask  = 6'd0;
    if (run) begin
      if (en_q == 3'b000) begin
        win_sel  = SEL_OUT;
        win_mask = 6'h3F;
      end else if (hit0_q) begin
        win_sel  = SEL_WIN0;
        win_mask = mask_w0_q;
      end else if (hit1_q) begin
        win_sel  = SEL_WIN1;
        win_mask = mask_w1_q;
      end else if (en_q[2] && obj_win) begin
        win_sel  = SEL_OBJ;
        win_mask = mask_obj_q;
      end else begin
        win_sel  = SEL_OUT;
        win_mask = mask_out_q;
      end
    end
  end

endmodule

// File: tb/tb_window_select_ctrl.sv
// tb/tb_window_select_ctrl.sv - randomized bench for window_select_ctrl against a spec-level pixel model.
module tb_window_select_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  vcount = '0;
  logic [2:0]  win_en = '0;
  logic [15:0] win0h = '0, win1h = '0, win0v = '0, win1v = '0;
  logic [13:0] winin = '0, winout = '0;
  logic        obj_valid = 1'b0, obj_win = 1'b0, out_ready = 1'b0;
  logic        obj_ready, out_valid, busy, line_done;
  logic [7:0]  pix_x;
  logic [1:0]  win_sel;
  logic [5:0]  win_mask;

  int vectors = 0;
  int miscompares = 0;

  int m_en, m_x1[2], m_x2[2], m_v[2], m_in0, m_in1, m_objm, m_outm;
  bit obj_bits[240];
  int exp_x;

  window_select_ctrl #(.SCREEN_W(240), .XW(8)) dut (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .vcount(vcount),
    .win_en(win_en), .win0h(win0h), .win1h(win1h), .win0v(win0v), .win1v(win1v),
    .winin(winin), .winout(winout), .obj_valid(obj_valid), .obj_win(obj_win),
    .obj_ready(obj_ready), .out_valid(out_valid), .out_ready(out_ready),
    .pix_x(pix_x), .win_sel(win_sel), .win_mask(win_mask), .busy(busy),
    .line_done(line_done)
  );

  always #5 clock = ~clock;

  function automatic bit inr(input int c, input int e1, input int e2);
    if (e1 < e2) return (c >= e1) && (c < e2);
    if (e1 > e2) return (c >= e1) || (c < e2);
    return 1'b0;
  endfunction

  function automatic int clampw(input int e);
    return (e > 240) ? 240 : e;
  endfunction

  // Pixel decision straight from the window rules, using the config captured at line start.
  task automatic ref_px(input int x, output int sel, output int mask);
    bit in0, in1, ino;
    in0 = m_en[0] && m_v[0] && inr(x, m_x1[0], m_x2[0]);
    in1 = m_en[1] && m_v[1] && inr(x, m_x1[1], m_x2[1]);
    ino = m_en[2] && obj_bits[x];
    if (m_en == 0) begin sel = 3; mask = 63; end
    else if (in0)  begin sel = 0; mask = m_in0; end
    else if (in1)  begin sel = 1; mask = m_in1; end
    else if (ino)  begin sel = 2; mask = m_objm; end
    else           begin sel = 3; mask = m_outm; end
  endtask

  task automatic start_line();
    out_ready  = 1'b0;
    line_start = 1'b1;
    m_en   = int'(win_en);
    m_x1[0] = clampw(int'(win0h[15:8])); m_x2[0] = clampw(int'(win0h[7:0]));
    m_x1[1] = clampw(int'(win1h[15:8])); m_x2[1] = clampw(int'(win1h[7:0]));
    m_v[0] = int'(inr(int'(vcount), int'(win0v[15:8]), int'(win0v[7:0])));
    m_v[1] = int'(inr(int'(vcount), int'(win1v[15:8]), int'(win1v[7:0])));
    m_in0  = int'(winin[5:0]);  m_in1 = int'(winin[13:8]);
    m_outm = int'(winout[5:0]); m_objm = int'(winout[13:8]);
    @(posedge clock); #1;
    line_start = 1'b0;
    exp_x = 0;
  endtask

  task automatic run_line(input int rdy_pct, input int ov_pct, input int stop_x,
                          input bit scramble, output int cycles);
    int sel, mask, psel, pmask, px;
    bit ev, hs, prev_stall;
    cycles = 0;
    prev_stall = 1'b0;
    psel = 0; pmask = 0; px = 0;
    while (exp_x < stop_x && cycles < 6000) begin
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      obj_valid = ($urandom_range(0, 99) < ov_pct);
      obj_win   = obj_bits[exp_x];
      if (scramble) begin
        win0h = 16'($urandom); win1h = 16'($urandom); win0v = 16'($urandom);
        win1v = 16'($urandom); winin = 14'($urandom); winout = 14'($urandom);
        win_en = 3'($urandom); vcount = 8'($urandom);
      end
      @(negedge clock);
      ev = obj_valid || !m_en[2];
      hs = ev && out_ready;
      vectors++;
      if (busy !== 1'b1 || out_valid !== ev || obj_ready !== hs) begin
        miscompares++;
        $display("FAIL handshake x=%0d: busy=%b valid=%b ready=%b want busy=1 valid=%b ready=%b",
                 exp_x, busy, out_valid, obj_ready, ev, hs);
      end
      if (ev) begin
        ref_px(exp_x, sel, mask);
        vectors++;
        if (pix_x !== 8'(exp_x) || win_sel !== 2'(sel) || win_mask !== 6'(mask)) begin
          miscompares++;
          $display("FAIL pixel: got x=%0d sel=%0d mask=%h want x=%0d sel=%0d mask=%h",
                   pix_x, win_sel, win_mask, exp_x, sel, mask);
        end
        if (prev_stall) begin
          vectors++;
          if (int'(pix_x) != px || int'(win_sel) != psel || int'(win_mask) != pmask) begin
            miscompares++;
            $display("FAIL stall_hold: got x=%0d sel=%0d mask=%h want x=%0d sel=%0d mask=%h",
                     pix_x, win_sel, win_mask, px, psel, pmask);
          end
        end
        px = int'(pix_x); psel = int'(win_sel); pmask = int'(win_mask);
      end
      prev_stall = ev && !out_ready;
      @(posedge clock); #1;
      cycles++;
      if (hs) exp_x++;
    end
    out_ready = 1'b0;
    if (exp_x < stop_x) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got x=%0d want %0d", exp_x, stop_x);
    end
  endtask

  task automatic check_line_end();
    vectors++;
    if (line_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL line_done_pulse: got done=%b busy=%b valid=%b want 1 0 0",
               line_done, busy, out_valid);
    end
    @(posedge clock); #1;
    vectors++;
    if (line_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_done: got done=%b busy=%b want 0 0", line_done, busy);
    end
  endtask

  task automatic clear_obj();
    for (int i = 0; i < 240; i++) obj_bits[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    vectors++;
    if ({out_valid, obj_ready, busy, line_done, pix_x, win_sel, win_mask} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
               {out_valid, obj_ready, busy, line_done, pix_x, win_sel, win_mask});
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_no_windows();
    int cyc;
    clear_obj();
    win_en = 3'b000; winout = 14'h0;
    start_line();
    run_line(100, 50, 240, 1'b0, cyc);
    vectors++;
    if (cyc != 240) begin
      miscompares++;
      $display("FAIL line_cycles: got %0d want 240", cyc);
    end
    check_line_end();
  endtask

  task automatic test_win0();
    int cyc;
    clear_obj();
    win0h = 16'h1050; win0v = 16'h0020; vcount = 8'd5;
    winin = 14'h0011; winout = 14'h0002; win_en = 3'b001;
    start_line();
    run_line(100, 30, 240, 1'b1, cyc);
    check_line_end();
  endtask

  task automatic test_wrap();
    int cyc;
    win1h = 16'hC820; win1v = 16'h00E4; vcount = 8'd100;
    winin = 14'h2A00; winout = 14'h0005; win_en = 3'b010;
    start_line();
    run_line(100, 0, 240, 1'b0, cyc);
    check_line_end();
  endtask

  task automatic test_overlap();
    int cyc;
    win0h = 16'h0A14; win1h = 16'h001E; win0v = 16'h00E4; win1v = 16'h00E4;
    vcount = 8'd60; winin = 14'h0C03; winout = 14'h0010; win_en = 3'b011;
    start_line();
    run_line(100, 0, 240, 1'b0, cyc);
    check_line_end();
    win0h = 16'h3030;
    start_line();
    run_line(100, 0, 240, 1'b0, cyc);
    check_line_end();
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 240; i++) obj_bits[i] = 1'($urandom);
    win_en = 3'b100; winout = 14'(($urandom & 14'h3F3F)); winin = 14'h0;
    start_line();
    run_line(60, 70, 240, 1'b1, cyc);
    check_line_end();
    for (int i = 0; i < 240; i++) obj_bits[i] = 1'($urandom);
    win0h = 16'($urandom); win1h = 16'($urandom); win0v = 16'($urandom_range(0, 255) << 8) | 16'hE4;
    win1v = 16'h5010; vcount = 8'($urandom_range(0, 227));
    winin = 14'($urandom); winout = 14'($urandom); win_en = 3'b111;
    start_line();
    run_line(70, 80, 240, 1'b1, cyc);
    check_line_end();
  endtask

  task automatic test_reset_and_restart();
    int cyc;
    clear_obj();
    win0h = 16'h2060; win0v = 16'h00E4; vcount = 8'd10;
    winin = 14'h0007; winout = 14'h0001; win_en = 3'b001;
    start_line();
    run_line(100, 0, 100, 1'b0, cyc);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, obj_ready, busy, line_done, pix_x, win_sel, win_mask} !== 20'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0",
               {out_valid, obj_ready, busy, line_done, pix_x, win_sel, win_mask});
    end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    win0h = 16'h2060; win_en = 3'b001;
    start_line();
    run_line(100, 0, 50, 1'b0, cyc);
    win0h = 16'h0008; win1h = 16'hF0F0; winin = 14'h0A15; winout = 14'h0033; win_en = 3'b011;
    win1v = 16'h00E4;
    start_line();
    run_line(80, 0, 240, 1'b0, cyc);
    check_line_end();
    start_line();
    run_line(100, 0, 240, 1'b0, cyc);
    vectors++;
    if (line_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_restart: got done=%b want 1", line_done);
    end
    start_line();
    run_line(100, 0, 5, 1'b0, cyc);
  endtask

  initial begin
    test_reset();
    test_no_windows();
    test_win0();
    test_wrap();
    test_overlap();
    test_back_to_back();
    test_reset_and_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
